// File: rtl/dp_mem_initiator.sv
// Datapath-side memory initiator: tags core load/store commands with TIDs, pushes them
// into the request FIFO and matches serve-FIFO responses against an outstanding table.
module dp_mem_initiator #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 31,
  parameter int TID_WIDTH     = 16,
  parameter int MAX_OUT       = 4,
  parameter int REQ_PKT_WIDTH = TID_WIDTH + 1 + ADDR_WIDTH + DATA_WIDTH,
  parameter int SRV_PKT_WIDTH = TID_WIDTH + DATA_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_we,
  input  logic [ADDR_WIDTH-1:0]    cmd_addr,
  input  logic [DATA_WIDTH-1:0]    cmd_wdata,
  output logic [TID_WIDTH-1:0]     cmd_tid,
  output logic [REQ_PKT_WIDTH-1:0] req_data,
  output logic                     req_wr,
  input  logic                     req_full,
  input  logic [SRV_PKT_WIDTH-1:0] srv_data,
  output logic                     srv_rd,
  input  logic                     srv_empty,
  output logic                     rsp_valid,
  output logic [TID_WIDTH-1:0]     rsp_tid,
  output logic                     rsp_we,
  output logic [DATA_WIDTH-1:0]    rsp_data,
  output logic                     busy,
  input  logic                     drain,
  output logic                     drain_done,
  output logic                     err_unknown_tid,
  output logic [1:0]               dbg_state
);

  localparam int CW = $clog2(MAX_OUT + 1);
  localparam int IW = $clog2(MAX_OUT);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUT);

  typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, DONE = 2'd2} state_t;

  state_t                 state;
  logic [MAX_OUT-1:0]     ent_valid;
  logic [MAX_OUT-1:0]     ent_we;
  logic [TID_WIDTH-1:0]   ent_tid [MAX_OUT];
  logic [CW-1:0]          count;
  logic [TID_WIDTH-1:0]   tid_ctr;
  logic                   pop_q;

  logic                   issue;
  logic                   hit;
  logic                   retire;
  logic [IW-1:0]          alloc_idx;
  logic [IW-1:0]          hit_idx;
  logic [TID_WIDTH-1:0]   srv_tid;
  logic [DATA_WIDTH-1:0]  srv_rdata;

  // Command handshake: a command transfers in any cycle where cmd_valid && cmd_ready;
  // cmd_ready never depends on cmd_valid, and req_wr mirrors the transfer exactly.
  assign cmd_ready = (state == RUN) && !req_full && (count < MAX_CNT);
  assign issue     = cmd_valid && cmd_ready;
  assign req_wr    = issue;
  assign req_data  = {tid_ctr, cmd_we, cmd_addr, cmd_wdata};
  assign cmd_tid   = tid_ctr;
  assign srv_rd    = !srv_empty && !rst;
  assign busy      = (count != '0);
  assign dbg_state = state;

  assign srv_tid   = srv_data[SRV_PKT_WIDTH-1 -: TID_WIDTH];
  assign srv_rdata = srv_data[DATA_WIDTH-1:0];

  always_comb begin
    alloc_idx = '0;
    for (int i = MAX_OUT - 1; i >= 0; i--) begin
      if (!ent_valid[i]) alloc_idx = IW'(i);
    end
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < MAX_OUT; i++) begin
      if (ent_valid[i] && (ent_tid[i] == srv_tid)) begin
        hit     = 1'b1;
        hit_idx = IW'(i);
      end
    end
  end

  assign retire = pop_q && hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= RUN;
      ent_valid       <= '0;
      ent_we          <= '0;
      for (int i = 0; i < MAX_OUT; i++) ent_tid[i] <= '0;
      count           <= '0;
      tid_ctr         <= '0;
      pop_q           <= 1'b0;
      rsp_valid       <= 1'b0;
      rsp_tid         <= '0;
      rsp_we          <= 1'b0;
      rsp_data        <= '0;
      drain_done      <= 1'b0;
      err_unknown_tid <= 1'b0;
    end else begin
      pop_q     <= srv_rd;
      rsp_valid <= retire;

      // Allocation looks only at pre-edge valid bits, so it never picks the retiring entry.
      if (issue) begin
        tid_ctr              <= tid_ctr + TID_WIDTH'(1);
        ent_valid[alloc_idx] <= 1'b1;
        ent_tid[alloc_idx]   <= tid_ctr;
        ent_we[alloc_idx]    <= cmd_we;
      end

      if (retire) begin
        ent_valid[hit_idx] <= 1'b0;
        rsp_tid            <= ent_tid[hit_idx];
        rsp_we             <= ent_we[hit_idx];
        rsp_data           <= srv_rdata;
      end

      if (pop_q && !hit) err_unknown_tid <= 1'b1;

      case ({issue, retire})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase

      drain_done <= 1'b0;
      case (state)
        RUN: begin
          if (drain) state <= DRAIN;
        end
        DRAIN: begin
          if (count == '0) begin
            state      <= DONE;
            drain_done <= 1'b1;
          end
        end
        DONE: begin
          state <= drain ? DRAIN : RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_dp_mem_initiator.sv
// Directed bench for dp_mem_initiator: a 16-bit-TID instance for the main scenarios and a
// 2-bit-TID instance for TID wrap-around, both driven from one linear initial block.
module tb_dp_mem_initiator;

  logic        clk;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [30:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [15:0] cmd_tid;
  logic [79:0] req_data;
  logic        req_wr, req_full;
  logic [47:0] srv_data;
  logic        srv_rd, srv_empty;
  logic        rsp_valid;
  logic [15:0] rsp_tid;
  logic        rsp_we;
  logic [31:0] rsp_data;
  logic        busy, drain, drain_done, err_unknown_tid;
  logic [1:0]  dbg_state;

  logic        w_cmd_valid, w_cmd_ready, w_cmd_we;
  logic [30:0] w_cmd_addr;
  logic [31:0] w_cmd_wdata;
  logic [1:0]  w_cmd_tid;
  logic [65:0] w_req_data;
  logic        w_req_wr, w_req_full;
  logic [33:0] w_srv_data;
  logic        w_srv_rd, w_srv_empty;
  logic        w_rsp_valid;
  logic [1:0]  w_rsp_tid;
  logic        w_rsp_we;
  logic [31:0] w_rsp_data;
  logic        w_busy, w_drain, w_drain_done, w_err;
  logic [1:0]  w_dbg_state;

  int errors = 0;
  int checks = 0;

  dp_mem_initiator dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_tid(cmd_tid),
    .req_data(req_data), .req_wr(req_wr), .req_full(req_full),
    .srv_data(srv_data), .srv_rd(srv_rd), .srv_empty(srv_empty),
    .rsp_valid(rsp_valid), .rsp_tid(rsp_tid), .rsp_we(rsp_we), .rsp_data(rsp_data),
    .busy(busy), .drain(drain), .drain_done(drain_done),
    .err_unknown_tid(err_unknown_tid), .dbg_state(dbg_state)
  );

  dp_mem_initiator #(.TID_WIDTH(2)) dut_wrap (
    .clk(clk), .rst(rst),
    .cmd_valid(w_cmd_valid), .cmd_ready(w_cmd_ready), .cmd_we(w_cmd_we),
    .cmd_addr(w_cmd_addr), .cmd_wdata(w_cmd_wdata), .cmd_tid(w_cmd_tid),
    .req_data(w_req_data), .req_wr(w_req_wr), .req_full(w_req_full),
    .srv_data(w_srv_data), .srv_rd(w_srv_rd), .srv_empty(w_srv_empty),
    .rsp_valid(w_rsp_valid), .rsp_tid(w_rsp_tid), .rsp_we(w_rsp_we), .rsp_data(w_rsp_data),
    .busy(w_busy), .drain(w_drain), .drain_done(w_drain_done),
    .err_unknown_tid(w_err), .dbg_state(w_dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Called mid-cycle; presents one command and checks the zero-latency request write.
  task automatic issue(input logic we, input logic [30:0] addr, input logic [31:0] wdata,
                       input logic [15:0] exp_tid, input logic [79:0] exp_pkt);
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    #1;
    chk("cmd_ready", cmd_ready, 1'b1);
    chk("req_wr", req_wr, 1'b1);
    chk("cmd_tid", cmd_tid, exp_tid);
    chk("req_data", req_data, exp_pkt);
    @(negedge clk);
    cmd_valid = 1'b0;
    #1;
    chk("req_wr_idle", req_wr, 1'b0);
  endtask

  // Models a registered-output FIFO holding one packet: pop in cycle n, data in n+1,
  // response expected in n+2.
  task automatic serve(input logic [15:0] tid, input logic [31:0] data,
                       input logic exp_hit, input logic exp_we);
    srv_empty = 1'b0;
    #1;
    chk("srv_rd", srv_rd, 1'b1);
    @(posedge clk);
    #1;
    srv_data  = {tid, data};
    srv_empty = 1'b1;
    @(negedge clk);
    chk("rsp_gap", rsp_valid, 1'b0);
    @(negedge clk);
    chk("rsp_valid", rsp_valid, exp_hit);
    if (exp_hit) begin
      chk("rsp_tid", rsp_tid, tid);
      chk("rsp_we", rsp_we, exp_we);
      chk("rsp_data", rsp_data, data);
    end
  endtask

  task automatic w_roundtrip(input logic [1:0] exp_tid, input logic [31:0] d);
    w_cmd_valid = 1'b1;
    w_cmd_we    = 1'b0;
    w_cmd_addr  = 31'h40;
    w_cmd_wdata = d;
    #1;
    chk("w_cmd_tid", w_cmd_tid, exp_tid);
    chk("w_req_tid", w_req_data[65:64], exp_tid);
    @(negedge clk);
    w_cmd_valid = 1'b0;
    w_srv_empty = 1'b0;
    @(posedge clk);
    #1;
    w_srv_data  = {exp_tid, d};
    w_srv_empty = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("w_rsp_valid", w_rsp_valid, 1'b1);
    chk("w_rsp_tid", w_rsp_tid, exp_tid);
    chk("w_rsp_data", w_rsp_data, d);
    chk("w_busy", w_busy, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    req_full = 1'b0; srv_data = '0; srv_empty = 1'b0; drain = 1'b0;
    w_cmd_valid = 1'b0; w_cmd_we = 1'b0; w_cmd_addr = '0; w_cmd_wdata = '0;
    w_req_full = 1'b0; w_srv_data = '0; w_srv_empty = 1'b1; w_drain = 1'b0;

    // Reset state; srv_rd must stay low while rst is high even with data waiting.
    repeat (2) @(negedge clk);
    #1;
    chk("rst_srv_rd", srv_rd, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_err", err_unknown_tid, 1'b0);
    chk("rst_drain_done", drain_done, 1'b0);
    chk("rst_state", dbg_state, 2'd0);
    srv_empty = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("idle_cmd_ready", cmd_ready, 1'b1);
    chk("idle_cmd_tid", cmd_tid, 16'h0);

    // Round trip: store to 0x10.
    @(negedge clk);
    issue(1'b1, 31'h10, 32'hDEAD_BEEF, 16'h0, 80'h0000_8000_0010_DEAD_BEEF);
    chk("rt_busy", busy, 1'b1);
    serve(16'h0, 32'h0, 1'b1, 1'b1);
    chk("rt_busy_done", busy, 1'b0);

    // Out-of-order return of three loads.
    do_reset();
    issue(1'b0, 31'h100, 32'hAAAA_0000, 16'h0, {16'h0, 1'b0, 31'h100, 32'hAAAA_0000});
    issue(1'b0, 31'h104, 32'hAAAA_0001, 16'h1, {16'h1, 1'b0, 31'h104, 32'hAAAA_0001});
    issue(1'b0, 31'h108, 32'hAAAA_0002, 16'h2, {16'h2, 1'b0, 31'h108, 32'hAAAA_0002});
    serve(16'h2, 32'h22, 1'b1, 1'b0);
    serve(16'h0, 32'h00, 1'b1, 1'b0);
    chk("ooo_busy_mid", busy, 1'b1);
    serve(16'h1, 32'h11, 1'b1, 1'b0);
    chk("ooo_busy_end", busy, 1'b0);

    // Outstanding limit: the fifth load waits for the first retire.
    do_reset();
    for (int i = 0; i < 4; i++)
      issue(1'b0, 31'(i), 32'h0, 16'(i), {16'(i), 1'b0, 31'(i), 32'h0});
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 31'h4; cmd_wdata = 32'h0;
    #1;
    chk("full_cmd_ready", cmd_ready, 1'b0);
    chk("full_req_wr", req_wr, 1'b0);
    serve(16'h0, 32'h5A, 1'b1, 1'b0);
    #1;
    chk("limit_cmd_ready", cmd_ready, 1'b1);
    chk("limit_req_wr", req_wr, 1'b1);
    chk("limit_cmd_tid", cmd_tid, 16'h4);
    @(negedge clk);
    cmd_valid = 1'b0;
    #1;
    chk("limit_refull", cmd_ready, 1'b0);

    // Request FIFO backpressure.
    do_reset();
    req_full = 1'b1;
    cmd_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_cmd_ready", cmd_ready, 1'b0);
      chk("bp_req_wr", req_wr, 1'b0);
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    req_full = 1'b0;

    // Unknown TID with nothing outstanding.
    do_reset();
    serve(16'h1234, 32'h55, 1'b0, 1'b0);
    chk("unk_err", err_unknown_tid, 1'b1);
    repeat (3) @(negedge clk);
    chk("unk_err_sticky", err_unknown_tid, 1'b1);
    chk("unk_no_rsp", rsp_valid, 1'b0);

    // Mid-operation reset discards outstanding entries.
    do_reset();
    chk("mr_err_cleared", err_unknown_tid, 1'b0);
    for (int i = 0; i < 3; i++)
      issue(1'b0, 31'h200, 32'h0, 16'(i), {16'(i), 1'b0, 31'h200, 32'h0});
    chk("mr_busy_before", busy, 1'b1);
    do_reset();
    #1;
    chk("mr_busy_after", busy, 1'b0);
    issue(1'b1, 31'h300, 32'h1, 16'h0, {16'h0, 1'b1, 31'h300, 32'h1});
    serve(16'h2, 32'h77, 1'b0, 1'b0);
    chk("mr_stale_err", err_unknown_tid, 1'b1);

    // Drain with two outstanding.
    do_reset();
    issue(1'b0, 31'h20, 32'h0, 16'h0, {16'h0, 1'b0, 31'h20, 32'h0});
    issue(1'b1, 31'h24, 32'h9, 16'h1, {16'h1, 1'b1, 31'h24, 32'h9});
    drain = 1'b1;
    @(negedge clk);
    chk("dr_state", dbg_state, 2'd1);
    chk("dr_cmd_ready", cmd_ready, 1'b0);
    serve(16'h1, 32'hB1, 1'b1, 1'b1);
    chk("dr_done_early", drain_done, 1'b0);
    serve(16'h0, 32'hB0, 1'b1, 1'b0);
    chk("dr_done_rsp_cycle", drain_done, 1'b0);
    drain = 1'b0;
    @(negedge clk);
    chk("dr_done_pulse", drain_done, 1'b1);
    @(negedge clk);
    chk("dr_done_once", drain_done, 1'b0);
    chk("dr_back_run", dbg_state, 2'd0);
    chk("dr_ready_again", cmd_ready, 1'b1);

    // Holding drain while idle pulses drain_done every second cycle.
    drain = 1'b1;
    @(negedge clk);
    chk("hold_c1", drain_done, 1'b0);
    @(negedge clk);
    chk("hold_c2", drain_done, 1'b1);
    @(negedge clk);
    chk("hold_c3", drain_done, 1'b0);
    @(negedge clk);
    chk("hold_c4", drain_done, 1'b1);
    drain = 1'b0;
    @(negedge clk);
    chk("hold_release", dbg_state, 2'd0);

    // TID wrap-around on the 2-bit instance.
    do_reset();
    w_roundtrip(2'd0, 32'h100);
    w_roundtrip(2'd1, 32'h101);
    w_roundtrip(2'd2, 32'h102);
    w_roundtrip(2'd3, 32'h103);
    w_roundtrip(2'd0, 32'h104);
    w_roundtrip(2'd1, 32'h105);
    chk("w_no_err", w_err, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
